// File: rtl/rv_regfile_pkg.sv
// Shared constants, register types and the write-port priority helper for the register file.
// Pure declarations: no latency, no flow control.
package rv_regfile_pkg;

  localparam int REG_ZERO   = 0;
  localparam int ADDR_W_MAX = 8;   // widest address any configuration may use
  localparam int DATA_W     = 32;
  localparam int MAX_WRITE  = 2;

  typedef logic [ADDR_W_MAX-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  typedef struct packed {
    logic hit;
    logic port;
  } wr_hit_t;

  // Later ports overwrite earlier matches, so the highest-index enabled port wins.
  function automatic wr_hit_t wr_hit(input logic [MAX_WRITE-1:0] en,
                                     input reg_addr_t [MAX_WRITE-1:0] wa,
                                     input reg_addr_t a);
    wr_hit_t h;
    h = '0;
    for (int i = 0; i < MAX_WRITE; i++) begin
      if (en[i] && wa[i] == a) begin
        h.hit  = 1'b1;
        h.port = 1'(i);
      end
    end
    return h;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-producer scoreboard: issue sets, writeback clears, and a same-cycle set beats the clear.
// State updates at the edge; rbusy is combinational from ra/write ports only, no backpressure.
module reg_scoreboard
  import rv_regfile_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int ADR_WIDTH = 5,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int BYPASS    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                iss_valid,
  input  logic [ADR_WIDTH-1:0]                iss_rd,
  input  logic [NUM_WRITE-1:0]                we,
  input  logic [NUM_WRITE-1:0][ADR_WIDTH-1:0] wa,
  input  logic [NUM_READ-1:0][ADR_WIDTH-1:0]  ra,
  output logic [NUM_READ-1:0]                 rbusy
);

  logic [REG_COUNT-1:0] pending;

  // we arrives pre-qualified (nonzero, in-range), so the clears need no extra address checks.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_WRITE; i++) begin
        if (we[i]) pending[wa[i]] <= 1'b0;
      end
      if (iss_valid && iss_rd != ADR_WIDTH'(REG_ZERO) && int'(iss_rd) < REG_COUNT)
        pending[iss_rd] <= 1'b1;
    end
  end

  always_comb begin
    rbusy = '0;
    for (int j = 0; j < NUM_READ; j++) begin
      if (ra[j] != ADR_WIDTH'(REG_ZERO) && int'(ra[j]) < REG_COUNT) begin
        rbusy[j] = pending[ra[j]];
        if (BYPASS != 0) begin
          for (int i = 0; i < NUM_WRITE; i++) begin
            if (we[i] && wa[i] == ra[j]) rbusy[j] = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with fixed write priority, optional write-to-read bypass and RAW scoreboard.
// Reads are zero-latency combinational, writes land at the edge; no backpressure on any port.
module regfile_multiport
  import rv_regfile_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int REG_WIDTH = 32,
  parameter int ADR_WIDTH = 5,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int BYPASS    = 1,
  parameter int A0_IDX    = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_WRITE-1:0]                we,
  input  logic [NUM_WRITE-1:0][ADR_WIDTH-1:0] wa,
  input  logic [NUM_WRITE-1:0][REG_WIDTH-1:0] wd,
  input  logic [NUM_READ-1:0][ADR_WIDTH-1:0]  ra,
  output logic [NUM_READ-1:0][REG_WIDTH-1:0]  rd,
  output logic [NUM_READ-1:0]                 rbusy,
  input  logic                                iss_valid,
  input  logic [ADR_WIDTH-1:0]                iss_rd,
  output logic [REG_WIDTH-1:0]                a0
);

  if (2**ADR_WIDTH < REG_COUNT) begin : g_chk_adr
    $error("ADR_WIDTH too narrow for REG_COUNT");
  end
  if (ADR_WIDTH > ADDR_W_MAX) begin : g_chk_adr_max
    $error("ADR_WIDTH exceeds reg_addr_t");
  end
  if (NUM_READ < 1 || NUM_READ > 4) begin : g_chk_rd
    $error("NUM_READ must be 1..4");
  end
  if (NUM_WRITE < 1 || NUM_WRITE > MAX_WRITE) begin : g_chk_wr
    $error("NUM_WRITE must be 1..2");
  end
  if (A0_IDX < 0 || A0_IDX >= REG_COUNT) begin : g_chk_a0
    $error("A0_IDX out of range");
  end

  logic [REG_WIDTH-1:0]       regs [REG_COUNT];
  logic [NUM_WRITE-1:0]       wr_ok;
  logic [MAX_WRITE-1:0]       hit_en;
  reg_addr_t [MAX_WRITE-1:0]  hit_adr;
  wr_hit_t [NUM_READ-1:0]     rd_hit;

  // Writes to x0 or beyond REG_COUNT are dropped here, so storage, bypass and scoreboard all agree.
  always_comb begin
    wr_ok   = '0;
    hit_en  = '0;
    hit_adr = '0;
    for (int i = 0; i < NUM_WRITE; i++) begin
      wr_ok[i]   = we[i] && wa[i] != ADR_WIDTH'(REG_ZERO) && int'(wa[i]) < REG_COUNT;
      hit_en[i]  = wr_ok[i];
      hit_adr[i] = reg_addr_t'(wa[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < REG_COUNT; k++) regs[k] <= '0;
    end else begin
      for (int i = 0; i < NUM_WRITE; i++) begin
        if (wr_ok[i]) regs[wa[i]] <= wd[i];
      end
    end
  end

  always_comb begin
    rd     = '0;
    rd_hit = '0;
    for (int j = 0; j < NUM_READ; j++) begin
      rd_hit[j] = wr_hit(hit_en, hit_adr, reg_addr_t'(ra[j]));
      if (ra[j] != ADR_WIDTH'(REG_ZERO) && int'(ra[j]) < REG_COUNT) begin
        if (BYPASS != 0 && rd_hit[j].hit) rd[j] = wd[rd_hit[j].port];
        else                              rd[j] = regs[ra[j]];
      end
    end
  end

  assign a0 = regs[A0_IDX];

  reg_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .ADR_WIDTH (ADR_WIDTH),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE),
    .BYPASS    (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .we        (wr_ok),
    .wa        (wa),
    .ra        (ra),
    .rbusy     (rbusy)
  );

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: one bypassing and one non-bypassing instance share all stimulus.
module tb_regfile_multiport;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        we;
  logic [1:0][4:0]   wa;
  logic [1:0][31:0]  wd;
  logic [1:0][4:0]   ra;
  logic              iss_valid;
  logic [4:0]        iss_rd;
  logic [1:0][31:0]  rd_b, rd_n;
  logic [1:0]        busy_b, busy_n;
  logic [31:0]       a0_b, a0_n;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem  [32];
  bit          pend [32];

  always #5 clk = ~clk;

  regfile_multiport #(.BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
    .rbusy(busy_b), .iss_valid(iss_valid), .iss_rd(iss_rd), .a0(a0_b)
  );

  regfile_multiport #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_n),
    .rbusy(busy_n), .iss_valid(iss_valid), .iss_rd(iss_rd), .a0(a0_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Architectural model: what an edge does to the register file and the producer set.
  task automatic model_update();
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        mem[k]  = '0;
        pend[k] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (we[i] && wa[i] != 0) begin
          mem[wa[i]]  = wd[i];
          pend[wa[i]] = 1'b0;
        end
      end
      if (iss_valid && iss_rd != 0) pend[iss_rd] = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (a == 0) return '0;
    if (byp) begin
      for (int i = 1; i >= 0; i--) if (we[i] && wa[i] == a) return wd[i];
    end
    return mem[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (byp && ((we[0] && wa[0] == a) || (we[1] && wa[1] == a))) return 1'b0;
    return pend[a];
  endfunction

  task automatic check_model(input string tag);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("%s.rd%0d_byp", tag, j), rd_b[j], exp_rd(1'b1, ra[j]));
      chk($sformatf("%s.rd%0d_nb", tag, j), rd_n[j], exp_rd(1'b0, ra[j]));
      chk($sformatf("%s.busy%0d_byp", tag, j), 32'(busy_b[j]), 32'(exp_busy(1'b1, ra[j])));
      chk($sformatf("%s.busy%0d_nb", tag, j), 32'(busy_n[j]), 32'(exp_busy(1'b0, ra[j])));
    end
    chk({tag, ".a0_byp"}, a0_b, mem[10]);
    chk({tag, ".a0_nb"}, a0_n, mem[10]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd = '0;
  endtask

  // Every address must read zero and not busy, with nothing being written.
  task automatic zero_sweep(input string tag);
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a);
      ra[1] = 5'(31 - a);
      #2;
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("%s.x%0d.rd%0d_byp", tag, ra[j], j), rd_b[j], 32'h0);
        chk($sformatf("%s.x%0d.rd%0d_nb", tag, ra[j], j), rd_n[j], 32'h0);
        chk($sformatf("%s.x%0d.busy%0d_byp", tag, ra[j], j), 32'(busy_b[j]), 32'h0);
        chk($sformatf("%s.x%0d.busy%0d_nb", tag, ra[j], j), 32'(busy_n[j]), 32'h0);
      end
      chk($sformatf("%s.a0_byp", tag), a0_b, 32'h0);
      chk($sformatf("%s.a0_nb", tag), a0_n, 32'h0);
      tick();
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra;
    logic        iss;
    logic [4:0]  ird;
    logic [31:0] rd_b, rd_n;
    logic        bz_b, bz_n;
    logic [31:0] a0;
  } vec_t;

  vec_t tv [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //         we     wa0 wa1 wd0           wd1           ra iss ird rd_b          rd_n          bzb bzn a0
    tv[0]  = '{2'b01, 0,  0,  32'hDEADBEEF, 32'h0,        0, 0,  0,  32'h0,        32'h0,        0,  0,  32'h0};
    tv[1]  = '{2'b00, 0,  0,  32'h0,        32'h0,        0, 0,  0,  32'h0,        32'h0,        0,  0,  32'h0};
    tv[2]  = '{2'b11, 5,  5,  32'h11111111, 32'h22222222, 5, 0,  0,  32'h22222222, 32'h0,        0,  0,  32'h0};
    tv[3]  = '{2'b00, 0,  0,  32'h0,        32'h0,        5, 0,  0,  32'h22222222, 32'h22222222, 0,  0,  32'h0};
    tv[4]  = '{2'b01, 7,  0,  32'hCAFEF00D, 32'h0,        7, 0,  0,  32'hCAFEF00D, 32'h0,        0,  0,  32'h0};
    tv[5]  = '{2'b00, 0,  0,  32'h0,        32'h0,        7, 0,  0,  32'hCAFEF00D, 32'hCAFEF00D, 0,  0,  32'h0};
    tv[6]  = '{2'b00, 0,  0,  32'h0,        32'h0,        3, 1,  3,  32'h0,        32'h0,        0,  0,  32'h0};
    tv[7]  = '{2'b00, 0,  0,  32'h0,        32'h0,        3, 0,  0,  32'h0,        32'h0,        1,  1,  32'h0};
    tv[8]  = '{2'b01, 3,  0,  32'h33,       32'h0,        3, 0,  0,  32'h33,       32'h0,        0,  1,  32'h0};
    tv[9]  = '{2'b00, 0,  0,  32'h0,        32'h0,        3, 0,  0,  32'h33,       32'h33,       0,  0,  32'h0};
    tv[10] = '{2'b10, 0,  3,  32'h0,        32'h44,       3, 1,  3,  32'h44,       32'h33,       0,  0,  32'h0};
    tv[11] = '{2'b00, 0,  0,  32'h0,        32'h0,        3, 0,  0,  32'h44,       32'h44,       1,  1,  32'h0};
    tv[12] = '{2'b01, 10, 0,  32'h42,       32'h0,       10, 0,  0,  32'h42,       32'h0,        0,  0,  32'h0};
    tv[13] = '{2'b00, 0,  0,  32'h0,        32'h0,       10, 0,  0,  32'h42,       32'h42,       0,  0,  32'h42};

    idle_inputs();
    ra  = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    zero_sweep("reset");

    for (int t = 0; t < 14; t++) begin
      we = tv[t].we;
      wa[0] = tv[t].wa0; wa[1] = tv[t].wa1;
      wd[0] = tv[t].wd0; wd[1] = tv[t].wd1;
      ra[0] = tv[t].ra;  ra[1] = tv[t].ra;
      iss_valid = tv[t].iss; iss_rd = tv[t].ird;
      #2;
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("vec%0d.rd%0d_byp", t, j), rd_b[j], tv[t].rd_b);
        chk($sformatf("vec%0d.rd%0d_nb", t, j), rd_n[j], tv[t].rd_n);
        chk($sformatf("vec%0d.busy%0d_byp", t, j), 32'(busy_b[j]), 32'(tv[t].bz_b));
        chk($sformatf("vec%0d.busy%0d_nb", t, j), 32'(busy_n[j]), 32'(tv[t].bz_n));
      end
      chk($sformatf("vec%0d.a0_byp", t), a0_b, tv[t].a0);
      chk($sformatf("vec%0d.a0_nb", t), a0_n, tv[t].a0);
      tick();
    end

    // Fill x1..x31 with their own index, mark x4 pending, then reset over a write and an issue.
    idle_inputs();
    for (int a = 1; a < 32; a += 2) begin
      we    = (a == 31) ? 2'b01 : 2'b11;
      wa[0] = 5'(a);     wd[0] = 32'(a);
      wa[1] = 5'(a + 1); wd[1] = 32'(a + 1);
      tick();
    end
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    idle_inputs();
    ra[0] = 5'd4; ra[1] = 5'd9;
    #2;
    chk("mid.busy4_byp", 32'(busy_b[0]), 32'h1);
    chk("mid.x9_nb", rd_n[1], 32'd9);
    check_model("mid");
    tick();
    rst = 1'b1;
    we = 2'b01; wa[0] = 5'd9; wd[0] = 32'hFFFF0009;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    zero_sweep("midrst");

    // Random traffic with address clustering so conflicts, bypasses and set/clear races occur.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        wa[i] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wd[i] = $urandom;
      end
      for (int j = 0; j < 2; j++)
        ra[j] = ($urandom_range(0, 2) == 0) ? wa[$urandom_range(0, 1)] : 5'($urandom_range(0, 11));
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom_range(0, 11));
      #2;
      if (!rst) check_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
